// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the three-requester memory arbiter:
//   - default parameter values for the arbiter
//   - requester IDs (IF / LS / DBG), used as indices into per-requester vectors
//   - the arbiter FSM state type
//   - a small saturating-increment helper for the IF starvation counter
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  // Default parameter values.
  localparam int ADDR_W_DEF     = 17;
  localparam int DATA_W_DEF     = 24;
  localparam int MEM_LAT_DEF    = 1;
  localparam int STARVE_MAX_DEF = 4;

  // Number of requesters sharing the memory port.
  localparam int N_REQ = 3;

  // Requester IDs. These double as bit positions in request/grant vectors.
  typedef logic [1:0] req_id_t;
  localparam req_id_t REQ_IF  = 2'd0;
  localparam req_id_t REQ_LS  = 2'd1;
  localparam req_id_t REQ_DBG = 2'd2;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,  // arbitrate among pending requests
    ACCESS = 2'd1,  // drive the memory port for one cycle, pulse x_gnt
    WAIT   = 2'd2,  // read latency beyond the first cycle
    RESP   = 2'd3   // return read data, pulse x_rvalid
  } arb_state_t;

  // Saturating increment of the 3-bit starvation counter.
  function automatic logic [2:0] starve_inc(input logic [2:0] cnt,
                                            input logic [2:0] lim);
    logic [2:0] res;
    res = (cnt >= lim) ? lim : cnt + 3'd1;
    return res;
  endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// ---------------------------------------------------------------------------
// arb_pick
// Combinational priority select for the memory arbiter.
//   Priority is DBG > LS > IF, except that IF wins outright when it is
//   requesting and has already lost STARVE_MAX consecutive arbitrations.
// Ports:
//   req        in  [N_REQ]  request vector, indexed by requester ID
//   starve_cnt in  [3]      consecutive IF losses so far
//   win_id     out [2]      ID of the winning requester (REQ_IF if none)
//   win_valid  out [1]      at least one request is present
// ---------------------------------------------------------------------------
module arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       starve_cnt,
  output req_id_t          win_id,
  output logic             win_valid
);

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  logic if_starved;

  assign if_starved = req[REQ_IF] && (starve_cnt == STARVE_LIM);

  always_comb begin
    win_id    = REQ_IF;
    win_valid = |req;
    if (if_starved) begin
      win_id = REQ_IF;
    end else if (req[REQ_DBG]) begin
      win_id = REQ_DBG;
    end else if (req[REQ_LS]) begin
      win_id = REQ_LS;
    end else begin
      win_id = REQ_IF;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port memory between three requesters: instruction fetch
// (IF, read-only), load/store (LS) and loader/debug (DBG). One transaction is
// in flight at a time; requests must be held by the requester until its
// grant pulse, nothing is queued.
//
// Timing for a request seen in IDLE at cycle T:
//   T+1           ACCESS: mem_en=1 with latched addr/we/wdata, x_gnt pulse
//   write         back to IDLE at T+2
//   read          WAIT for MEM_LAT-1 cycles, RESP at T+1+MEM_LAT with
//                 rdata=mem_rdata and x_rvalid pulse, IDLE at T+2+MEM_LAT
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   if_req/if_addr               IF read requests
//   ls_req/ls_we/ls_addr/ls_wdata     LS requests
//   dbg_req/dbg_we/dbg_addr/dbg_wdata DBG requests
//   if_gnt/ls_gnt/dbg_gnt        one-cycle accept pulses (in ACCESS)
//   if_rvalid/ls_rvalid/dbg_rvalid one-cycle read-data-valid pulses (in RESP)
//   rdata                        read data, zero unless an rvalid is high
//   mem_en/mem_we/mem_addr/mem_wdata memory port, zero outside ACCESS
//   mem_rdata                    memory read data, valid MEM_LAT cycles
//                                after mem_en
//   busy                         high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MEM_LAT    = MEM_LAT_DEF,    // 1..7
  parameter int STARVE_MAX = STARVE_MAX_DEF  // 1..7
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,

  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,

  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,

  output logic              if_gnt,
  output logic              ls_gnt,
  output logic              dbg_gnt,
  output logic              if_rvalid,
  output logic              ls_rvalid,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] rdata,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              busy
);

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);
  // Cycles spent in WAIT for a read; zero when MEM_LAT is 1.
  localparam logic [2:0] WAIT_CYCLES = 3'(MEM_LAT - 1);

  // -------------------------------------------------------------------------
  // Per-requester views of the inputs, indexed by requester ID
  // -------------------------------------------------------------------------
  logic [N_REQ-1:0]  req_vec;
  logic              we_arr    [N_REQ];
  logic [ADDR_W-1:0] addr_arr  [N_REQ];
  logic [DATA_W-1:0] wdata_arr [N_REQ];

  assign req_vec[REQ_IF]    = if_req;
  assign req_vec[REQ_LS]    = ls_req;
  assign req_vec[REQ_DBG]   = dbg_req;

  // IF is read-only: it never writes and has no write data.
  assign we_arr[REQ_IF]     = 1'b0;
  assign we_arr[REQ_LS]     = ls_we;
  assign we_arr[REQ_DBG]    = dbg_we;

  assign addr_arr[REQ_IF]   = if_addr;
  assign addr_arr[REQ_LS]   = ls_addr;
  assign addr_arr[REQ_DBG]  = dbg_addr;

  assign wdata_arr[REQ_IF]  = '0;
  assign wdata_arr[REQ_LS]  = ls_wdata;
  assign wdata_arr[REQ_DBG] = dbg_wdata;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  arb_state_t        state_reg,  state_next;
  req_id_t           owner_reg,  owner_next;
  logic [ADDR_W-1:0] addr_reg,   addr_next;
  logic              we_reg,     we_next;
  logic [DATA_W-1:0] wdata_reg,  wdata_next;
  logic [2:0]        starve_reg, starve_next;
  logic [2:0]        wait_reg,   wait_next;

  req_id_t           win_id;
  logic              win_valid;

  arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .req        (req_vec),
    .starve_cnt (starve_reg),
    .win_id     (win_id),
    .win_valid  (win_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      owner_reg  <= REQ_IF;
      addr_reg   <= '0;
      we_reg     <= 1'b0;
      wdata_reg  <= '0;
      starve_reg <= '0;
      wait_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      owner_reg  <= owner_next;
      addr_reg   <= addr_next;
      we_reg     <= we_next;
      wdata_reg  <= wdata_next;
      starve_reg <= starve_next;
      wait_reg   <= wait_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    owner_next  = owner_reg;
    addr_next   = addr_reg;
    we_next     = we_reg;
    wdata_next  = wdata_reg;
    starve_next = starve_reg;
    wait_next   = wait_reg;

    case (state_reg)
      IDLE: begin
        if (win_valid) begin
          // Capture everything now so the requester is free to change its
          // inputs as soon as it sees the grant.
          owner_next = win_id;
          addr_next  = addr_arr[win_id];
          we_next    = we_arr[win_id];
          wdata_next = wdata_arr[win_id];
          state_next = ACCESS;
        end
        // The counter only tracks consecutive losses while IF keeps asking;
        // a grant to IF or IF going quiet starts it over.
        if (!if_req || (win_id == REQ_IF)) begin
          starve_next = '0;
        end else begin
          starve_next = starve_inc(starve_reg, STARVE_LIM);
        end
      end

      ACCESS: begin
        if (we_reg) begin
          state_next = IDLE;
        end else if (WAIT_CYCLES == 3'd0) begin
          state_next = RESP;
        end else begin
          state_next = WAIT;
          wait_next  = WAIT_CYCLES;
        end
      end

      WAIT: begin
        if (wait_reg <= 3'd1) begin
          state_next = RESP;
          wait_next  = '0;
        end else begin
          wait_next = wait_reg - 3'd1;
        end
      end

      RESP: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs: decoded purely from registered state, so they are all zero in
  // the cycle after reset and never depend combinationally on requests.
  // -------------------------------------------------------------------------
  logic              in_access;
  logic              in_resp;
  logic [N_REQ-1:0]  gnt_vec;
  logic [N_REQ-1:0]  rvalid_vec;

  assign in_access = (state_reg == ACCESS);
  assign in_resp   = (state_reg == RESP);

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_owner_dec
    assign gnt_vec[gi]    = in_access && (owner_reg == req_id_t'(gi));
    assign rvalid_vec[gi] = in_resp   && (owner_reg == req_id_t'(gi));
  end

  assign if_gnt     = gnt_vec[REQ_IF];
  assign ls_gnt     = gnt_vec[REQ_LS];
  assign dbg_gnt    = gnt_vec[REQ_DBG];
  assign if_rvalid  = rvalid_vec[REQ_IF];
  assign ls_rvalid  = rvalid_vec[REQ_LS];
  assign dbg_rvalid = rvalid_vec[REQ_DBG];

  assign rdata      = in_resp ? mem_rdata : '0;

  assign mem_en     = in_access;
  assign mem_we     = in_access && we_reg;
  assign mem_addr   = in_access ? addr_reg  : '0;
  assign mem_wdata  = in_access ? wdata_reg : '0;

  assign busy       = (state_reg != IDLE);

endmodule
